// File: rtl/checkpoint_alloc_ctrl_pkg.sv
// checkpoint_alloc_ctrl_pkg: shared constants and types for the branch checkpoint allocator
package checkpoint_alloc_ctrl_pkg;

    localparam int CHKPT_NUM  = 4;
    localparam int CHKPT_ID_W = 2;
    localparam int ROB_TAG_W  = 5;

    typedef enum logic {IDLE, RECOVER} chkpt_ctrl_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic [ROB_TAG_W-1:0] rob_tag;
    } chkpt_meta_t;

endpackage

// File: rtl/checkpoint_alloc_ctrl_tag_cam.sv
// chkpt_tag_cam: combinational ROB-tag match over the valid checkpoint slots
module chkpt_tag_cam
    import checkpoint_alloc_ctrl_pkg::*;
#(
    parameter int N    = CHKPT_NUM,
    parameter int ID_W = CHKPT_ID_W
) (
    input  chkpt_meta_t          slots [N],
    input  logic [ROB_TAG_W-1:0] tag,
    output logic                 hit,
    output logic [ID_W-1:0]      idx
);

    // Scan from the top down so the lowest matching slot wins if tags ever alias
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (slots[i].valid && slots[i].rob_tag == tag) begin
                hit = 1'b1;
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/checkpoint_alloc_ctrl.sv
// checkpoint_alloc_ctrl: in-order allocation, release and mispredict recovery of branch checkpoints
module checkpoint_alloc_ctrl
    import checkpoint_alloc_ctrl_pkg::*;
#(
    parameter int NUM_CHKPT = CHKPT_NUM,
    parameter int ID_W      = CHKPT_ID_W,
    parameter int TAG_W     = ROB_TAG_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req,
    input  logic [TAG_W-1:0]     alloc_rob_tag,
    output logic                 alloc_grant,
    output logic [ID_W-1:0]      alloc_id,
    output logic                 rename_stall,
    input  logic                 resolve_valid,
    input  logic [TAG_W-1:0]     resolve_tag,
    input  logic                 mispredict,
    input  logic [TAG_W-1:0]     mispredict_tag,
    output logic                 restore_valid,
    output logic [ID_W-1:0]      restore_id,
    output logic [NUM_CHKPT-1:0] squash_mask,
    output logic                 release_valid,
    output logic [ID_W-1:0]      release_id,
    output logic [NUM_CHKPT-1:0] valid_mask,
    output logic [ID_W:0]        count,
    output logic                 mispredict_miss
);

    chkpt_ctrl_state_e     state_q, state_d;
    chkpt_meta_t           meta_q [NUM_CHKPT];
    chkpt_meta_t           meta_d [NUM_CHKPT];
    logic [ID_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]         count_q, count_d;
    logic                  restore_valid_q, restore_valid_d;
    logic [ID_W-1:0]       restore_id_q, restore_id_d;
    logic [NUM_CHKPT-1:0]  squash_mask_q, squash_mask_d;
    logic                  release_valid_q, release_valid_d;
    logic [ID_W-1:0]       release_id_q, release_id_d;
    logic                  miss_q, miss_d;
    logic                  alloc_ready, release_fire;
    logic                  rs_hit, mp_hit;
    logic [ID_W-1:0]       rs_idx, mp_idx, keep;

    chkpt_tag_cam #(.N(NUM_CHKPT), .ID_W(ID_W)) u_resolve_cam (
        .slots (meta_q),
        .tag   (resolve_tag),
        .hit   (rs_hit),
        .idx   (rs_idx)
    );

    chkpt_tag_cam #(.N(NUM_CHKPT), .ID_W(ID_W)) u_mispredict_cam (
        .slots (meta_q),
        .tag   (mispredict_tag),
        .hit   (mp_hit),
        .idx   (mp_idx)
    );

    // Fullness is judged on the current count only, so a same-cycle release never unblocks rename
    assign alloc_ready  = (state_q == IDLE) && (count_q < (ID_W+1)'(NUM_CHKPT));
    assign alloc_grant  = alloc_req && alloc_ready && !mispredict;
    assign rename_stall = alloc_req && !alloc_ready;
    assign alloc_id     = tail_q;
    assign release_fire = meta_q[head_q].valid && meta_q[head_q].resolved && !mispredict;
    assign keep         = mp_idx - head_q;

    assign restore_valid   = restore_valid_q;
    assign restore_id      = restore_id_q;
    assign squash_mask     = squash_mask_q;
    assign release_valid   = release_valid_q;
    assign release_id      = release_id_q;
    assign count           = count_q;
    assign mispredict_miss = miss_q;

    // Occupancy view of the slot array
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < NUM_CHKPT; i++) valid_mask[i] = meta_q[i].valid;
    end

    // Next state: a mispredict pre-empts everything; otherwise resolve, release and allocate together
    always_comb begin
        state_d         = (state_q == RECOVER) ? IDLE : state_q;
        meta_d          = meta_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        restore_valid_d = 1'b0;
        restore_id_d    = '0;
        squash_mask_d   = '0;
        release_valid_d = 1'b0;
        release_id_d    = '0;
        miss_d          = 1'b0;
        if (mispredict) begin
            if (mp_hit) begin
                // Slots whose age offset from head is at least that of the mispredicted one are younger-or-equal
                for (int i = 0; i < NUM_CHKPT; i++) begin
                    if (meta_q[i].valid && (ID_W'(i) - head_q) >= keep) begin
                        meta_d[i].valid    = 1'b0;
                        meta_d[i].resolved = 1'b0;
                        squash_mask_d[i]   = 1'b1;
                    end
                end
                tail_d          = mp_idx;
                count_d         = {1'b0, keep};
                restore_valid_d = 1'b1;
                restore_id_d    = mp_idx;
                state_d         = RECOVER;
            end else begin
                miss_d = 1'b1;
            end
        end else begin
            if (resolve_valid && rs_hit) meta_d[rs_idx].resolved = 1'b1;
            if (release_fire) begin
                meta_d[head_q].valid    = 1'b0;
                meta_d[head_q].resolved = 1'b0;
                head_d                  = head_q + 1'b1;
                release_valid_d         = 1'b1;
                release_id_d            = head_q;
            end
            if (alloc_grant) begin
                meta_d[tail_q].valid    = 1'b1;
                meta_d[tail_q].resolved = 1'b0;
                meta_d[tail_q].rob_tag  = alloc_rob_tag;
                tail_d                  = tail_q + 1'b1;
            end
            count_d = count_q + (ID_W+1)'(alloc_grant) - (ID_W+1)'(release_fire);
        end
    end

    // State and registered pulse outputs; reset also aborts any recovery in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            restore_valid_q <= 1'b0;
            restore_id_q    <= '0;
            squash_mask_q   <= '0;
            release_valid_q <= 1'b0;
            release_id_q    <= '0;
            miss_q          <= 1'b0;
            for (int i = 0; i < NUM_CHKPT; i++) meta_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            restore_valid_q <= restore_valid_d;
            restore_id_q    <= restore_id_d;
            squash_mask_q   <= squash_mask_d;
            release_valid_q <= release_valid_d;
            release_id_q    <= release_id_d;
            miss_q          <= miss_d;
            meta_q          <= meta_d;
        end
    end

endmodule

// File: doc/checkpoint_alloc_ctrl.md
Name: checkpoint_alloc_ctrl

Overview:
- Allocation and recovery controller for the 4-entry branch checkpoint store.
- Sits between rename, ROB and the checkpoint store.
- Hands out checkpoint slots in program order and stalls rename when all slots are in use.
- Retires slots in order once their branch resolves correctly; on a mispredict, selects the slot to restore and squashes every younger slot.

Parameters:
- NUM_CHKPT, 4, number of checkpoint slots; power of two.
- ID_W, 2, slot index width; equals log2(NUM_CHKPT).
- TAG_W, 5, ROB tag width (32-entry ROB).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_req  in  1  rename has a branch this cycle
- alloc_rob_tag  in  TAG_W  ROB tag of that branch
- alloc_grant  out  1  slot granted this cycle (combinational)
- alloc_id  out  ID_W  granted slot, equal to the tail pointer (combinational)
- rename_stall  out  1  equals alloc_req && !alloc_ready
- resolve_valid  in  1  branch resolved, prediction correct
- resolve_tag  in  TAG_W  ROB tag of the resolved branch
- mispredict  in  1  branch resolved, prediction wrong
- mispredict_tag  in  TAG_W  ROB tag of the mispredicted branch
- restore_valid  out  1  registered pulse: restore from restore_id
- restore_id  out  ID_W  slot to restore
- squash_mask  out  NUM_CHKPT  registered pulse: slots invalidated
- release_valid  out  1  registered pulse: slot retired in order
- release_id  out  ID_W  retired slot
- valid_mask  out  NUM_CHKPT  current occupancy
- count  out  ID_W+1  occupied slots
- mispredict_miss  out  1  registered pulse: mispredict_tag matched no slot

Behaviour:
- State
  - Circular queue: head, tail (ID_W bits, wrap modulo NUM_CHKPT), count.
  - Per slot: valid, resolved, rob_tag.
  - FSM: IDLE, RECOVER.
- Reset
  - All pointers, count, valid and resolved bits cleared; FSM to IDLE.
  - All registered outputs 0.
  - Reset in RECOVER aborts recovery and gives the same cleared state.
- Allocate
  - alloc_ready = (state==IDLE) && (count < NUM_CHKPT).
  - alloc_grant = alloc_req && alloc_ready && !mispredict.
  - On grant, at the clock edge: slot[tail] gets valid=1, resolved=0, rob_tag=alloc_rob_tag; tail increments.
  - Full is decided on the current count. A release in the same cycle does not unblock a stalled allocation.
- Resolve
  - CAM resolve_tag against valid slots; on a hit set resolved=1.
  - A miss, or a slot already resolved, is a no-op.
- Release
  - When valid[head] && resolved[head] and there is no mispredict this cycle: clear the slot, increment head, pulse release_valid and release_id=old head on the next cycle.
  - At most one release per cycle.
  - Allocation and release in the same cycle leave count unchanged.
- Mispredict
  - Highest priority; blocks allocation, resolve and release that cycle.
  - CAM hit at slot m: squash every slot from m up to tail-1, in circular order; m itself is included.
  - Then set tail=m and count=(m-head) mod NUM_CHKPT.
  - Next cycle: restore_valid=1, restore_id=m, squash_mask = the squashed slots, FSM to RECOVER.
  - RECOVER lasts exactly 1 cycle (alloc_ready=0), then returns to IDLE.
  - Miss: no state change; mispredict_miss pulses next cycle.
  - A mispredict arriving while in RECOVER is processed normally.
- Width rules
  - Pointer arithmetic is modulo 2^ID_W.
  - count is ID_W+1 bits so it can hold NUM_CHKPT.

Decomposition:
- types_pkg gets:
  - CHKPT_NUM, CHKPT_ID_W, ROB_TAG_W constants.
  - typedef enum chkpt_ctrl_state_e {IDLE, RECOVER}.
  - struct chkpt_meta_t {valid, resolved, rob_tag}.
- One sub-module, chkpt_tag_cam: combinational tag match over the slot array. Returns hit and index; instanced twice, for resolve and mispredict.

Test Plan:
- Reset, then 4 allocs with tags 3,7,9,12 -> alloc_id 0,1,2,3, count=4; a 5th alloc_req gives rename_stall=1, alloc_grant=0.
- Resolve tag 3 -> release_valid with release_id=0 the next cycle, count=3. Resolve tag 9 before tag 7 -> no release until tag 7 resolves, then releases of ids 1 and 2 on consecutive cycles.
- With ids 0-3 holding tags 3,7,9,12, mispredict tag 7 -> next cycle restore_valid=1, restore_id=1, squash_mask=4'b1110; tail=1, count=1; alloc blocked for 1 cycle, then the next alloc gets id 1.
- Wrap: head=3, tail=1 (slots 3,0 live); mispredict the tag in slot 0 -> squash_mask=4'b0001, count=1.
- Same cycle mispredict + alloc_req + resolve of the head -> only the mispredict takes effect: no grant and no release.
- Mispredict with an unknown tag 31 -> mispredict_miss pulse, state unchanged. Reset asserted during RECOVER -> all outputs 0 and count=0 the next cycle.
